// File: rtl/stepper_io_controller.sv
// rtl/stepper_io_controller.sv - autonomous mailbox-driven stepper sequencer on the RAM IO port (optional STEPPER_HOLD_TORQUE_EN)
module stepper_io_controller #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] CMD_ADDR  = 12'hFF0,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 12'hFF1,
    parameter int                POLL_DIV  = 1000,
    parameter int                STEP_DIV  = 100000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] IO_addr,
    output logic              IO_wEn,
    output logic [31:0]       IO_dataOut,
    input  logic [31:0]       IO_dataIn,
    output logic [5:0]        JA,
    output logic              busy
);

    localparam int PW = $clog2(POLL_DIV);
    localparam int SW = $clog2(STEP_DIV);

    typedef enum logic [2:0] {
        IDLE_WAIT,
        RD_CMD,
        RD_WAIT,
        CLR_CMD,
        RUN,
        WR_STAT
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     poll_q, poll_d;
    logic [SW-1:0]     step_q, step_d;
    logic [2:0]        idx_q, idx_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [15:0]       completed_q, completed_d;
    logic              dir_q, dir_d;
    logic              half_q, half_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [2:0]        next_idx;
    logic [1:0]        pair_next;
    logic [3:0]        coils;
    logic              unused_cmd_bits;

    // Command bits 28:16 carry no meaning for this block.
    assign unused_cmd_bits = ^IO_dataIn[28:16];

    function automatic logic [3:0] pattern_of(input logic [2:0] i);
        case (i)
            3'd0:    pattern_of = 4'b1000;
            3'd1:    pattern_of = 4'b1010;
            3'd2:    pattern_of = 4'b0010;
            3'd3:    pattern_of = 4'b0110;
            3'd4:    pattern_of = 4'b0100;
            3'd5:    pattern_of = 4'b0101;
            3'd6:    pattern_of = 4'b0001;
            default: pattern_of = 4'b1001;
        endcase
    endfunction

    // Next phase index: half-step walks every entry, full-step moves between odd (two-coil) entries.
    always_comb begin
        pair_next = dir_q ? (idx_q[2:1] + 2'd1) : (idx_q[2:1] - 2'd1);
        if (half_q) begin
            next_idx = dir_q ? (idx_q + 3'd1) : (idx_q - 3'd1);
        end else begin
            next_idx = {pair_next, 1'b1};
        end
    end

    // Sequencer: poll mailbox, accept and clear command, step the coils, report status.
    always_comb begin
        state_d     = state_q;
        poll_d      = poll_q;
        step_d      = step_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        completed_d = completed_q;
        dir_d       = dir_q;
        half_d      = half_q;
        err_d       = err_q;
        addr_d      = addr_q;
        case (state_q)
            IDLE_WAIT: begin
                if (poll_q == PW'(POLL_DIV - 1)) begin
                    poll_d  = '0;
                    addr_d  = CMD_ADDR;
                    state_d = RD_CMD;
                end else begin
                    poll_d = poll_q + PW'(1);
                end
            end
            RD_CMD: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (IO_dataIn[31]) begin
                    dir_d       = IO_dataIn[30];
                    half_d      = IO_dataIn[29];
                    remaining_d = IO_dataIn[15:0];
                    completed_d = '0;
                    state_d     = CLR_CMD;
                end else begin
                    state_d = IDLE_WAIT;
                end
            end
            CLR_CMD: begin
                if (remaining_q == 16'd0) begin
                    err_d   = 1'b1;
                    addr_d  = STAT_ADDR;
                    state_d = WR_STAT;
                end else begin
                    err_d   = 1'b0;
                    step_d  = SW'(STEP_DIV - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // The final pattern is shown for one cycle before the status write.
                if (remaining_q == 16'd0) begin
                    addr_d  = STAT_ADDR;
                    state_d = WR_STAT;
                end else if (step_q == '0) begin
                    step_d      = SW'(STEP_DIV - 1);
                    idx_d       = next_idx;
                    remaining_d = remaining_q - 16'd1;
                    completed_d = completed_q + 16'd1;
                end else begin
                    step_d = step_q - SW'(1);
                end
            end
            WR_STAT: begin
                poll_d  = '0;
                state_d = IDLE_WAIT;
            end
            default: begin
                state_d = IDLE_WAIT;
            end
        endcase
    end

    // State register; reset abandons any run without a status write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE_WAIT;
            poll_q      <= '0;
            step_q      <= '0;
            idx_q       <= 3'd0;
            remaining_q <= '0;
            completed_q <= '0;
            dir_q       <= 1'b0;
            half_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            poll_q      <= poll_d;
            step_q      <= step_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            completed_q <= completed_d;
            dir_q       <= dir_d;
            half_q      <= half_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
        end
    end

    // Output decode from registered state; address register holds its value while idle.
    always_comb begin
        busy       = (state_q != IDLE_WAIT);
        IO_addr    = addr_q;
        IO_wEn     = (state_q == CLR_CMD) || (state_q == WR_STAT);
        IO_dataOut = (state_q == WR_STAT) ? {1'b1, err_q, 11'b0, idx_q, completed_q} : 32'd0;
        coils      = pattern_of(idx_q);
`ifdef STEPPER_HOLD_TORQUE_EN
        JA         = {busy, 1'b1, coils};
`else
        JA         = (state_q == RUN) ? {busy, 1'b1, coils} : {busy, 5'b0};
`endif
    end

endmodule
